alu_exec_unit: RTL

//   Execute stage directly downstream of alu_control: consumes alu_ctr plus two operands and produces a registered result.

---
 rtl/alu_exec_unit_if.sv | 70 +++++++
 rtl/alu_exec_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Handshake bundle between the producer (decode/alu_control side plus the
//   result consumer) and the alu_exec_unit execute stage.
//   Optional feature macro: ALU_EXEC_OVF_EN (adds the ovf flag).
//
//   Signals
//     in_valid   operands + alu_ctr valid               (master -> slave)
//     in_ready   unit can accept an operation            (slave  -> master)
//     alu_ctr    operation select                        (master -> slave)
//     src_a      operand A                               (master -> slave)
//     src_b      operand B                               (master -> slave)
//     out_valid  result/result_hi/zero valid             (slave  -> master)
//     out_ready  consumer takes the result this cycle    (master -> slave)
//     result     result, low half of product for MULT    (slave  -> master)
//     result_hi  high half of product for MULT, else 0   (slave  -> master)
//     zero       registered (result == 0)                (slave  -> master)
//     ovf        signed overflow, ALU_EXEC_OVF_EN only   (slave  -> master)
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctr;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
`ifdef ALU_EXEC_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid,
        input  in_ready,
        output alu_ctr,
        output src_a,
        output src_b,
        input  out_valid,
        output out_ready,
        input  result,
        input  result_hi,
        input  zero
`ifdef ALU_EXEC_OVF_EN
        ,
        input  ovf
`endif
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  alu_ctr,
        input  src_a,
        input  src_b,
        output out_valid,
        input  out_ready,
        output result,
        output result_hi,
        output zero
`ifdef ALU_EXEC_OVF_EN
        ,
        output ovf
`endif
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage behind alu_control. Codes 000-110 complete in one cycle;
//   code 111 is an iterative unsigned shift-add multiply producing a
//   2*WIDTH-bit product over WIDTH cycles. Valid/ready on both sides lets the
//   pipeline stall around the multiply and around a blocked consumer.
//   Optional feature macro: ALU_EXEC_OVF_EN (signed overflow flag on ovf).
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_exec_unit_if.slave (handshakes, operands, results)
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | accepting ops; single-cycle results registered directly
//   MUL   | shift-add multiply in progress, input side stalled
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_exec_unit_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MULT = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_result_hi;
    logic                 r_zero;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_slt;
    logic [WIDTH-1:0]     w_res;
    logic [2*WIDTH-1:0]   w_acc_next;

`ifdef ALU_EXEC_OVF_EN
    logic                 r_ovf;
    logic                 w_ovf;
`endif

    // rst_n gates in_ready so nothing looks acceptable while held in reset.
    assign w_in_ready = rst_n && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_sum  = bus.src_a + bus.src_b;
    assign w_diff = bus.src_a - bus.src_b;
    assign w_slt  = $signed(bus.src_a) < $signed(bus.src_b);

    always_comb begin
        w_res = '0;
        case (bus.alu_ctr)
            OP_AND:  w_res = bus.src_a & bus.src_b;
            OP_OR:   w_res = bus.src_a | bus.src_b;
            OP_ADD:  w_res = w_sum;
            OP_XOR:  w_res = bus.src_a ^ bus.src_b;
            OP_NOR:  w_res = ~(bus.src_a | bus.src_b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SUB:  w_res = w_diff;
            default: w_res = '0;
        endcase
    end

`ifdef ALU_EXEC_OVF_EN
    always_comb begin
        w_ovf = 1'b0;
        case (bus.alu_ctr)
            OP_ADD:  w_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1]  != bus.src_a[WIDTH-1]);
            OP_SUB:  w_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != bus.src_a[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end
`endif

    // Multiplicand is pre-shifted each cycle and the multiplier shifted right,
    // so bit 0 of r_mplier is always the current B[count].
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
`ifdef ALU_EXEC_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.alu_ctr != OP_MULT) begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_zero      <= (w_res == '0);
                            r_out_valid <= 1'b1;
`ifdef ALU_EXEC_OVF_EN
                            r_ovf       <= w_ovf;
`endif
                        end else begin
                            // Accept implies any pending result is consumed now.
                            r_mcand     <= {{WIDTH{1'b0}}, bus.src_a};
                            r_mplier    <= bus.src_b;
                            r_acc       <= '0;
                            r_cnt       <= CNT_LAST;
                            r_out_valid <= 1'b0;
                            r_state     <= S_MUL;
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef ALU_EXEC_OVF_EN
                        r_ovf       <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.zero      = r_zero;
`ifdef ALU_EXEC_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
